fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter that funnels N_REQ word streams into a single FIFO write port.
// A grant is held until Last, MAX_BURST words, or the owner abandons; Full stalls the burst indefinitely.
module fifo_write_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BURST = 8,
    localparam int unsigned OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req,
    input  logic [N_REQ-1:0]         Last,
    input  logic [N_REQ*WIDTH-1:0]   Req_Data,
    input  logic                     Full,
    output logic [N_REQ-1:0]         Grant,
    output logic [N_REQ-1:0]         Ack,
    output logic                     WE,
    output logic [WIDTH-1:0]         Write_Data,
    output logic                     Busy,
    output logic [OW-1:0]            Owner
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q,   cnt_d;

    logic               pick_found_c;
    logic [OW-1:0]      pick_idx_c;
    logic [OW-1:0]      cand_c;
    logic [N_REQ-1:0]   ack_c;
    logic               we_c;
    logic [WIDTH-1:0]   wdata_c;
    logic               owner_req_c;
    logic               owner_last_c;
    logic               burst_end_c;

    // Round-robin search starting just above the current owner; the owner itself comes last.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = owner_q;
        cand_c       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_c = OW'((32'(owner_q) + k) % N_REQ);
            if (!pick_found_c && Req[cand_c]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = cand_c;
            end
        end
    end

    // Accept path: only the owner, only when the FIFO has room and reset is released.
    always_comb begin
        ack_c = '0;
        if (Reset && (state_q == BURST) && !Full) begin
            ack_c = grant_q & Req;
        end
    end

    assign we_c = |ack_c;

    always_comb begin
        wdata_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (ack_c[i]) begin
                wdata_c = Req_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign owner_req_c  = |(grant_q & Req);
    assign owner_last_c = |(grant_q & Last);

    // Last, the word limit and abandonment all collapse into one end event.
    assign burst_end_c = (state_q == BURST) &&
                         ((we_c && (owner_last_c || (cnt_q == CW'(MAX_BURST - 1)))) ||
                          (!owner_req_c && !Full));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    state_d = BURST;
                    grant_d = N_REQ'(1) << pick_idx_c;
                    owner_d = pick_idx_c;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (burst_end_c) begin
                    cnt_d = '0;
                    if (pick_found_c) begin
                        grant_d = N_REQ'(1) << pick_idx_c;
                        owner_d = pick_idx_c;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (we_c) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset leaves Owner at the top index so requester 0 wins first.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= OW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Grant      = grant_q;
    assign Owner      = owner_q;
    assign Ack        = ack_c;
    assign WE         = we_c;
    assign Write_Data = wdata_c;
    assign Busy       = Reset && (state_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a cycle table plus hand-written multi-cycle sequences.
module tb_fifo_write_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  Req;
    logic [3:0]  Last;
    logic [63:0] Req_Data;
    logic        Full;
    logic [3:0]  Grant;
    logic [3:0]  Ack;
    logic        WE;
    logic [15:0] Write_Data;
    logic        Busy;
    logic [1:0]  Owner;

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .Last       (Last),
        .Req_Data   (Req_Data),
        .Full       (Full),
        .Grant      (Grant),
        .Ack        (Ack),
        .WE         (WE),
        .Write_Data (Write_Data),
        .Busy       (Busy),
        .Owner      (Owner)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic        full;
        logic [15:0] d;
        logic [3:0]  e_grant;
        logic [3:0]  e_ack;
        logic        e_we;
        logic [15:0] e_wd;
        logic        e_busy;
        logic [1:0]  e_owner;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] last,
                                input logic full, input logic [15:0] d, input logic [3:0] e_grant,
                                input logic [3:0] e_ack, input logic e_we, input logic [15:0] e_wd,
                                input logic e_busy, input logic [1:0] e_owner);
        vec_t v;
        v.rst = rst; v.req = req; v.last = last; v.full = full; v.d = d;
        v.e_grant = e_grant; v.e_ack = e_ack; v.e_we = e_we; v.e_wd = e_wd;
        v.e_busy = e_busy; v.e_owner = e_owner;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester i presents d with its index folded into the top nibble.
    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] last,
                         input logic full, input logic [15:0] d);
        @(negedge Clock);
        Reset = rst;
        Req   = req;
        Last  = last;
        Full  = full;
        for (int i = 0; i < 4; i++) Req_Data[i*16 +: 16] = d ^ (16'(i) << 12);
        #2;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0);
    endtask

    vec_t tbl[17];
    int   words;
    int   cyc;

    initial begin
        Reset = 1'b0; Req = '0; Last = '0; Full = 1'b0; Req_Data = '0;

        //          rst  req      last     full d         grant    ack      we  wd        busy own
        tbl[0]  = mk(0, 4'b1111, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2'd3);
        tbl[1]  = mk(1, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2'd3);
        tbl[2]  = mk(1, 4'b0001, 4'b0000, 0, 16'h0100, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2'd3);
        tbl[3]  = mk(1, 4'b0001, 4'b0000, 0, 16'h0100, 4'b0001, 4'b0001, 1, 16'h0100, 1, 2'd0);
        tbl[4]  = mk(1, 4'b0001, 4'b0000, 0, 16'h1050, 4'b0001, 4'b0001, 1, 16'h1050, 1, 2'd0);
        tbl[5]  = mk(1, 4'b0001, 4'b0001, 0, 16'h2000, 4'b0001, 4'b0001, 1, 16'h2000, 1, 2'd0);
        tbl[6]  = mk(1, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0001, 4'b0000, 0, 16'h0000, 1, 2'd0);
        tbl[7]  = mk(1, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2'd0);
        tbl[8]  = mk(1, 4'b0010, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2'd0);
        tbl[9]  = mk(1, 4'b1010, 4'b0000, 0, 16'hA000, 4'b0010, 4'b0010, 1, 16'hB000, 1, 2'd1);
        tbl[10] = mk(1, 4'b1010, 4'b0000, 0, 16'hA001, 4'b0010, 4'b0010, 1, 16'hB001, 1, 2'd1);
        tbl[11] = mk(1, 4'b1000, 4'b0000, 0, 16'hA002, 4'b0010, 4'b0000, 0, 16'h0000, 1, 2'd1);
        tbl[12] = mk(1, 4'b1000, 4'b1000, 1, 16'h0005, 4'b1000, 4'b0000, 0, 16'h0000, 1, 2'd3);
        tbl[13] = mk(1, 4'b0000, 4'b0000, 1, 16'h0006, 4'b1000, 4'b0000, 0, 16'h0000, 1, 2'd3);
        tbl[14] = mk(1, 4'b1000, 4'b1000, 0, 16'h0007, 4'b1000, 4'b1000, 1, 16'h3007, 1, 2'd3);
        tbl[15] = mk(1, 4'b0000, 4'b0000, 0, 16'h0000, 4'b1000, 4'b0000, 0, 16'h0000, 1, 2'd3);
        tbl[16] = mk(1, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, 4'b0000, 0, 16'h0000, 0, 2'd3);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].last, tbl[i].full, tbl[i].d);
            chk($sformatf("v%0d.grant", i), 32'(Grant),      32'(tbl[i].e_grant));
            chk($sformatf("v%0d.ack", i),   32'(Ack),        32'(tbl[i].e_ack));
            chk($sformatf("v%0d.we", i),    32'(WE),         32'(tbl[i].e_we));
            chk($sformatf("v%0d.wd", i),    32'(Write_Data), 32'(tbl[i].e_wd));
            chk($sformatf("v%0d.busy", i),  32'(Busy),       32'(tbl[i].e_busy));
            chk($sformatf("v%0d.owner", i), 32'(Owner),      32'(tbl[i].e_owner));
        end

        // All four requesting: 0,1,2,3,0 with eight back-to-back writes each.
        do_reset();
        drive(1'b1, 4'b1111, 4'b0000, 1'b0, 16'h0);
        chk("rr.idle_grant", 32'(Grant), 32'h0);
        cyc = 0;
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < 8; w++) begin
                cyc++;
                drive(1'b1, 4'b1111, 4'b0000, 1'b0, 16'(cyc));
                chk($sformatf("rr.b%0d.w%0d.grant", b, w), 32'(Grant), 32'(4'b0001 << (b % 4)));
                chk($sformatf("rr.b%0d.w%0d.ack", b, w),   32'(Ack),   32'(4'b0001 << (b % 4)));
                chk($sformatf("rr.b%0d.w%0d.wd", b, w),    32'(Write_Data),
                    32'(16'(cyc) ^ (16'(b % 4) << 12)));
            end
        end

        // Owner 2 stalls five cycles on Full after its third word; still exactly eight words.
        do_reset();
        drive(1'b1, 4'b0100, 4'b0000, 1'b0, 16'h0);
        words = 0;
        for (int c = 0; c < 13; c++) begin
            drive(1'b1, 4'b0100, 4'b0000, (c >= 3 && c <= 7), 16'(c));
            chk($sformatf("stall.c%0d.grant", c), 32'(Grant), 32'(4'b0100));
            chk($sformatf("stall.c%0d.we", c),    32'(WE),     32'((c >= 3 && c <= 7) ? 0 : 1));
            if (WE) words++;
        end
        chk("stall.words", 32'(words), 32'd8);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0);
        chk("stall.regrant_abandon_we", 32'(WE), 32'h0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0);
        chk("stall.idle_busy", 32'(Busy), 32'h0);

        // Reset during owner 3's fourth word aborts; requester 0 then wins first.
        do_reset();
        drive(1'b1, 4'b1000, 4'b0000, 1'b0, 16'h0);
        for (int w = 0; w < 3; w++) begin
            drive(1'b1, 4'b1000, 4'b0000, 1'b0, 16'(w));
            chk($sformatf("rst.w%0d.we", w), 32'(WE), 32'h1);
        end
        drive(1'b0, 4'b1000, 4'b0000, 1'b0, 16'h0033);
        chk("rst.in_reset.ack",  32'(Ack),        32'h0);
        chk("rst.in_reset.we",   32'(WE),         32'h0);
        chk("rst.in_reset.wd",   32'(Write_Data), 32'h0);
        chk("rst.in_reset.busy", 32'(Busy),       32'h0);
        drive(1'b1, 4'b1001, 4'b0000, 1'b0, 16'h0);
        chk("rst.after.grant", 32'(Grant), 32'h0);
        chk("rst.after.we",    32'(WE),    32'h0);
        chk("rst.after.owner", 32'(Owner), 32'd3);
        drive(1'b1, 4'b1001, 4'b0000, 1'b0, 16'h0);
        chk("rst.first.grant", 32'(Grant), 32'(4'b0001));
        chk("rst.first.owner", 32'(Owner), 32'd0);

        // Last on the eighth word ends once; sole requester re-wins with a fresh count.
        do_reset();
        drive(1'b1, 4'b0001, 4'b0000, 1'b0, 16'h0);
        for (int w = 0; w < 8; w++) begin
            drive(1'b1, 4'b0001, (w == 7) ? 4'b0001 : 4'b0000, 1'b0, 16'(w));
            chk($sformatf("l8.a.w%0d.we", w), 32'(WE), 32'h1);
        end
        for (int w = 0; w < 8; w++) begin
            drive(1'b1, 4'b0011, 4'b0000, 1'b0, 16'(w));
            chk($sformatf("l8.b.w%0d.grant", w), 32'(Grant), 32'(4'b0001));
            chk($sformatf("l8.b.w%0d.we", w),    32'(WE),    32'h1);
        end
        drive(1'b1, 4'b0011, 4'b0000, 1'b0, 16'h0);
        chk("l8.next.grant", 32'(Grant), 32'(4'b0010));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
